mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one mux4_registered datapath among four requesters.
- Drives the datapath's sel and wr_en, returns per-requester acknowledges, and supports bounded burst ownership.
- Produces out_valid and out_src, aligned cycle-for-cycle with the registered datapath output.
- Sits between four producer blocks and the shared registered mux in the CPU datapath.

---
 rtl/mux4_rr_arbiter.sv | 113 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one registered 4:1 datapath mux among four requesters,
// with bounded burst ownership and output-valid/source tracking aligned to the datapath register.
module mux4_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       hold,
  output logic [3:0] ack,
  output logic [1:0] sel,
  output logic       wr_en,
  output logic       busy,
  output logic       out_valid,
  output logic [1:0] out_src
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} st_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  st_t           st_q, st_d;
  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    out_src_q, out_src_d;

  logic          gnt_s;
  logic          cont_s;
  logic [1:0]    win_s;
  logic [1:0]    base_s;
  logic [1:0]    idx_s;

  // Grant decision: continue the current burst, else scan from the rotating start point.
  always_comb begin
    gnt_s  = 1'b0;
    cont_s = 1'b0;
    win_s  = owner_q;
    idx_s  = 2'd0;
    base_s = (st_q == BURST) ? (owner_q + 2'd1) : ptr_q;
    if (!rst && !hold) begin
      if ((st_q == BURST) && req[owner_q] && (cnt_q < MAX_CNT)) begin
        gnt_s  = 1'b1;
        cont_s = 1'b1;
      end else begin
        // Walk from the farthest offset down so the nearest requester is assigned last.
        for (int i = 3; i >= 0; i--) begin
          idx_s = base_s + 2'(i);
          if (req[idx_s]) begin
            gnt_s = 1'b1;
            win_s = idx_s;
          end else begin
            gnt_s = gnt_s;
          end
        end
      end
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Next-state for ownership, burst count, rotation pointer and output tracking.
  always_comb begin
    st_d        = st_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    out_valid_d = gnt_s;
    out_src_d   = gnt_s ? win_s : out_src_q;
    if (hold) begin
      st_d = st_q;
    end else if (gnt_s) begin
      owner_d = win_s;
      cnt_d   = cont_s ? (cnt_q + ONE_CNT) : ONE_CNT;
      st_d    = BURST;
    end else if (st_q == BURST) begin
      st_d  = IDLE;
      ptr_d = owner_q + 2'd1;
    end else begin
      st_d = IDLE;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      owner_q     <= 2'd0;
      cnt_q       <= '0;
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_src_q   <= 2'd0;
    end else begin
      st_q        <= st_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

  assign ack       = gnt_s ? (4'b0001 << win_s) : 4'b0000;
  assign sel       = win_s;
  assign wr_en     = gnt_s;
  assign busy      = (st_q == BURST);
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus constrained-random
// traffic compared against a behavioural round-robin/burst model.
module tb_mux4_rr_arbiter;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       hold;
  logic [3:0] ack;
  logic [1:0] sel;
  logic       wr_en, busy, out_valid;
  logic [1:0] out_src;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_busy, m_ov;
  int m_owner, m_cnt, m_ptr, m_osrc;
  bit e_gnt, e_cont;
  int e_win;
  logic [3:0] obs_ack;

  mux4_rr_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .hold(hold), .ack(ack), .sel(sel),
    .wr_en(wr_en), .busy(busy), .out_valid(out_valid), .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0; m_ov = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_osrc = 0;
  endfunction

  function automatic void predict();
    int start;
    e_gnt = 1'b0; e_cont = 1'b0; e_win = m_owner;
    if (!rst && !hold) begin
      if (m_busy && req[m_owner] && m_cnt < MB) begin
        e_gnt = 1'b1; e_cont = 1'b1;
      end else begin
        start = m_busy ? (m_owner + 1) % 4 : m_ptr;
        for (int i = 0; i < 4; i++)
          if (!e_gnt && req[(start + i) % 4]) begin
            e_gnt = 1'b1; e_win = (start + i) % 4;
          end
      end
    end
  endfunction

  // One cycle: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    predict();
    obs_ack = ack;
    check_eq("ack", ack, e_gnt ? (1 << e_win) : 0);
    check_eq("sel", sel, e_win);
    check_eq("wr_en", wr_en, e_gnt);
    check_eq("busy", busy, m_busy);
    check_eq("out_valid", out_valid, m_ov);
    check_eq("out_src", out_src, m_osrc);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_ov = e_gnt;
      if (e_gnt) begin
        m_osrc = e_win;
        m_cnt = e_cont ? m_cnt + 1 : 1;
        m_owner = e_win;
        m_busy = 1'b1;
      end else if (!hold && m_busy) begin
        m_busy = 1'b0;
        m_ptr = (m_owner + 1) % 4;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; hold = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b0;

    // Idle with no requests
    repeat (5) step();

    // All requesting: bursts of MB, rotating with no gaps
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("rr_seq", obs_ack, 1 << ((i / MB) % 4));
    end

    // Single requester keeps the grant across burst boundaries
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("solo", obs_ack, 4'b0100);
    end

    // Owner 1 drops after two transfers, scan continues from 2
    rst = 1'b1; model_reset(); step(); rst = 1'b0;
    req = 4'b0010; step();
    req = 4'b1011; step(); check_eq("own1_cont", obs_ack, 4'b0010);
    req = 4'b1001; step(); check_eq("next3", obs_ack, 4'b1000);
    req = 4'b0001; step(); check_eq("then0", obs_ack, 4'b0001);
    req = 4'b0000; step(); step();
    req = 4'b1111; step(); check_eq("ptr1", obs_ack, 4'b0010);

    // Hold freezes the burst
    req = 4'b0011; step();
    hold = 1'b1;
    repeat (3) begin
      step();
      check_eq("hold_ack", obs_ack, 4'b0000);
    end
    hold = 1'b0; step(); check_eq("resume", obs_ack, 4'b0010);
    req = 4'b0000; step(); step();

    // Asynchronous reset mid-burst
    req = 4'b1111; step(); step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_eq("arst_ack", ack, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ov", out_valid, 0);
    check_eq("arst_wr", wr_en, 0);
    step();
    rst = 1'b0; req = 4'b1000; step();
    check_eq("post_rst", obs_ack, 4'b1000);

    // Randomized traffic obeying the hold-until-ack protocol
    for (int c = 0; c < 1500; c++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; model_reset();
      end
      for (int k = 0; k < 4; k++)
        if (obs_ack[k] || !req[k]) req[k] = ($urandom_range(0, 9) < 6);
      hold = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
